// File: rtl/gpv_vector_sequencer_if.sv
// rtl/gpv_vector_sequencer_if.sv - per-channel request bus for the GPV vector sequencer
interface gpv_vector_sequencer_if #(
  parameter int NUM_CH       = 2,
  parameter int VECTOR_WIDTH = 256,
  parameter int FIELD_MAX    = 64,
  parameter int CNT_W        = 16
);
  localparam int PW = $clog2(VECTOR_WIDTH);

  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH-1:0]           req_ready;
  logic [NUM_CH*PW-1:0]        req_start;
  logic [NUM_CH*PW-1:0]        req_end;
  logic [NUM_CH*FIELD_MAX-1:0] req_val;
  logic [NUM_CH*CNT_W-1:0]     req_wait;
  logic [NUM_CH*CNT_W-1:0]     req_pulse;

  modport master (
    output req_valid, req_start, req_end, req_val, req_wait, req_pulse,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_start, req_end, req_val, req_wait, req_pulse,
    output req_ready
  );
endinterface

// File: rtl/gpv_vector_sequencer.sv
// rtl/gpv_vector_sequencer.sv - multi-channel queued, cycle-scheduled bit-field driver
module gpv_vector_sequencer #(
  parameter int                      VECTOR_WIDTH = 256,
  parameter int                      FIELD_MAX    = 64,
  parameter int                      NUM_CH       = 2,
  parameter int                      DEPTH        = 4,
  parameter int                      CNT_W        = 16,
  parameter logic [VECTOR_WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  gpv_vector_sequencer_if.slave    req,
  output logic [VECTOR_WIDTH-1:0]  vector,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err
);
  localparam int PW = $clog2(VECTOR_WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [VECTOR_WIDTH-1:0] ONES = '1;
  localparam logic [PW-1:0]           TOP  = PW'(VECTOR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY, PULSE} state_t;

  typedef struct packed {
    logic [PW-1:0]        s;
    logic [PW-1:0]        e;
    logic [FIELD_MAX-1:0] v;
    logic [CNT_W-1:0]     w;
    logic [CNT_W-1:0]     p;
  } req_t;

  req_t             mem    [NUM_CH][DEPTH];
  logic [AW-1:0]    wr_ptr [NUM_CH];
  logic [AW-1:0]    rd_ptr [NUM_CH];
  logic [AW:0]      count  [NUM_CH];
  state_t           state  [NUM_CH];
  req_t             cur    [NUM_CH];
  logic [CNT_W-1:0] cnt    [NUM_CH];

  req_t                    in_req   [NUM_CH];
  logic [VECTOR_WIDTH-1:0] fld_mask [NUM_CH];
  logic [VECTOR_WIDTH-1:0] fld_data [NUM_CH];
  logic [NUM_CH-1:0]       in_ok, push, pop, full;
  logic [VECTOR_WIDTH-1:0] next_vec;

  always_comb begin
    req.req_ready = '0;
    ch_busy       = '0;
    in_ok         = '0;
    push          = '0;
    pop           = '0;
    full          = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_req[ch].s = req.req_start[ch*PW +: PW];
      in_req[ch].e = req.req_end[ch*PW +: PW];
      in_req[ch].v = req.req_val[ch*FIELD_MAX +: FIELD_MAX];
      in_req[ch].w = req.req_wait[ch*CNT_W +: CNT_W];
      in_req[ch].p = req.req_pulse[ch*CNT_W +: CNT_W];
      in_ok[ch] = !((in_req[ch].e < in_req[ch].s) ||
                    (32'(in_req[ch].e) >= VECTOR_WIDTH) ||
                    (32'(in_req[ch].e) - 32'(in_req[ch].s) + 32'd1 > FIELD_MAX));
      full[ch]          = (count[ch] == (AW+1)'(DEPTH));
      req.req_ready[ch] = !rst && !full[ch];
      push[ch]          = req.req_valid[ch] && req.req_ready[ch] && in_ok[ch];
      pop[ch]           = (state[ch] == IDLE) && (count[ch] != '0);
      ch_busy[ch]       = (state[ch] != IDLE) || (count[ch] != '0);
    end
  end

  // Channels are merged in ascending order so the highest index wins overlapping bits.
  always_comb begin
    next_vec = vector;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      fld_mask[ch] = (ONES << cur[ch].s) & (ONES >> (TOP - cur[ch].e));
      fld_data[ch] = VECTOR_WIDTH'(cur[ch].v) << cur[ch].s;
      if (state[ch] == APPLY)
        next_vec = (next_vec & ~fld_mask[ch]) | (fld_data[ch] & fld_mask[ch]);
      else if (state[ch] == PULSE && cnt[ch] == '0)
        next_vec = (next_vec & ~fld_mask[ch]) | (RESET_VAL & fld_mask[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vector <= RESET_VAL;
      done   <= '0;
      err    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state[ch]  <= IDLE;
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        count[ch]  <= '0;
        cnt[ch]    <= '0;
        cur[ch]    <= '0;
      end
    end else begin
      vector <= next_vec;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        done[ch] <= 1'b0;
        err[ch]  <= req.req_valid[ch] && req.req_ready[ch] && !in_ok[ch];
        if (push[ch]) begin
          mem[ch][wr_ptr[ch]] <= in_req[ch];
          wr_ptr[ch]          <= wr_ptr[ch] + AW'(1);
        end
        count[ch] <= count[ch] + {{AW{1'b0}}, push[ch]} - {{AW{1'b0}}, pop[ch]};
        case (state[ch])
          IDLE: if (pop[ch]) begin
            cur[ch]    <= mem[ch][rd_ptr[ch]];
            cnt[ch]    <= mem[ch][rd_ptr[ch]].w;
            rd_ptr[ch] <= rd_ptr[ch] + AW'(1);
            state[ch]  <= WAIT;
          end
          WAIT: if (cnt[ch] == '0) state[ch] <= APPLY;
                else cnt[ch] <= cnt[ch] - CNT_W'(1);
          APPLY: if (cur[ch].p == '0) begin
            done[ch]  <= 1'b1;
            state[ch] <= IDLE;
          end else begin
            cnt[ch]   <= cur[ch].p - CNT_W'(1);
            state[ch] <= PULSE;
          end
          PULSE: if (cnt[ch] == '0) begin
            done[ch]  <= 1'b1;
            state[ch] <= IDLE;
          end else cnt[ch] <= cnt[ch] - CNT_W'(1);
          default: state[ch] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpv_vector_sequencer.sv
// tb/tb_gpv_vector_sequencer.sv - directed self-checking bench for gpv_vector_sequencer
module tb_gpv_vector_sequencer;
  // A non-power-of-two width makes end >= VECTOR_WIDTH representable on the port.
  localparam int VW  = 200;
  localparam int FM  = 64;
  localparam int NC  = 2;
  localparam int DEP = 4;
  localparam int CW  = 16;
  localparam int PW  = $clog2(VW);

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] vector;
  logic [NC-1:0] ch_busy, done, err;
  logic [VW-1:0] model;
  logic [VW-1:0] expv;
  int            checks = 0;
  int            failures = 0;

  gpv_vector_sequencer_if #(.NUM_CH(NC), .VECTOR_WIDTH(VW), .FIELD_MAX(FM), .CNT_W(CW)) bus ();

  gpv_vector_sequencer #(
    .VECTOR_WIDTH(VW), .FIELD_MAX(FM), .NUM_CH(NC), .DEPTH(DEP), .CNT_W(CW), .RESET_VAL('0)
  ) dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .vector(vector), .ch_busy(ch_busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input int s, input int e, input logic [FM-1:0] v,
                         input int w, input int p);
    bus.req_start[ch*PW +: PW] = PW'(s);
    bus.req_end[ch*PW +: PW]   = PW'(e);
    bus.req_val[ch*FM +: FM]   = v;
    bus.req_wait[ch*CW +: CW]  = CW'(w);
    bus.req_pulse[ch*CW +: CW] = CW'(p);
    bus.req_valid[ch]          = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (vector !== '0) begin failures++; $display("FAIL reset_vector got=%h exp=0", vector); end
    checks++; if (done !== 2'b00 || err !== 2'b00) begin failures++; $display("FAIL reset_pulses got done=%b err=%b exp=00", done, err); end
    checks++; if (ch_busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", ch_busy); end
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready_low got=%b exp=00", bus.req_ready); end
    rst = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL reset_ready_high got=%b exp=11", bus.req_ready); end
    model = '0;
  endtask

  task automatic test_hold;
    set_req(0, 8, 15, 64'hA5, 0, 0);
    tick();
    bus.req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      expv = model;
      if (k >= 3) expv[15:8] = 8'hA5;
      checks++; if (vector !== expv) begin failures++; $display("FAIL hold_vector k=%0d got=%h exp=%h", k, vector, expv); end
      checks++; if (done[0] !== (k == 3)) begin failures++; $display("FAIL hold_done k=%0d got=%b exp=%b", k, done[0], k == 3); end
    end
    checks++; if (ch_busy[0] !== 1'b0) begin failures++; $display("FAIL hold_busy_after got=%b exp=0", ch_busy[0]); end
    model[15:8] = 8'hA5;
  endtask

  task automatic test_pulse;
    set_req(1, 0, 3, 64'hF, 5, 4);
    tick();
    bus.req_valid = '0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      expv = model;
      if (k >= 8 && k < 12) expv[3:0] = 4'hF;
      checks++; if (vector !== expv) begin failures++; $display("FAIL pulse_vector k=%0d got=%h exp=%h", k, vector, expv); end
      checks++; if (done !== {(k == 12), 1'b0}) begin failures++; $display("FAIL pulse_done k=%0d got=%b exp=%b", k, done, {(k == 12), 1'b0}); end
    end
  endtask

  task automatic test_same_cycle;
    set_req(0, 4, 11, 64'h00, 0, 0);
    set_req(1, 4, 11, 64'hFF, 0, 0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    checks++; if (vector !== model) begin failures++; $display("FAIL overlap_early got=%h exp=%h", vector, model); end
    tick();
    model[11:4] = 8'hFF;
    checks++; if (vector !== model) begin failures++; $display("FAIL overlap_vector got=%h exp=%h", vector, model); end
    checks++; if (done !== 2'b11) begin failures++; $display("FAIL overlap_done got=%b exp=11", done); end
    set_req(0, 32, 39, 64'h3C, 0, 0);
    set_req(1, 40, 47, 64'hC3, 0, 0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    model[47:32] = 16'hC33C;
    checks++; if (vector !== model) begin failures++; $display("FAIL disjoint_vector got=%h exp=%h", vector, model); end
  endtask

  task automatic test_boundary;
    set_req(0, 100, 103, 64'hFFFF_FFFF_FFFF_FFF5, 0, 0);
    set_req(1, 136, 199, 64'h8000_0000_0000_0001, 0, 0);
    tick();
    bus.req_valid = '0;
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL boundary_err got=%b exp=00", err); end
    tick();
    tick();
    tick();
    model[103:100] = 4'h5;
    model[136] = 1'b1;
    model[199] = 1'b1;
    checks++; if (vector !== model) begin failures++; $display("FAIL boundary_vector got=%h exp=%h", vector, model); end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c <= 68; c++) begin
      if (c < 5) set_req(0, 48 + 8*c, 55 + 8*c, 64'(8'h11 * (c + 1)), 10, 0);
      else bus.req_valid = '0;
      tick();
      expv = model;
      for (int k = 0; k < 5; k++)
        if (c >= 13 + 13*k) expv[48 + 8*k +: 8] = 8'(8'h11 * (k + 1));
      checks++; if (vector !== expv) begin failures++; $display("FAIL fifo_vector c=%0d got=%h exp=%h", c, vector, expv); end
      checks++; if (done[0] !== (c >= 13 && c <= 65 && c % 13 == 0)) begin failures++; $display("FAIL fifo_done c=%0d got=%b", c, done[0]); end
      if (c == 4 || c == 13) begin
        checks++; if (bus.req_ready[0] !== 1'b0) begin failures++; $display("FAIL fifo_ready_low c=%0d got=%b exp=0", c, bus.req_ready[0]); end
      end
      if (c == 14) begin
        checks++; if (bus.req_ready[0] !== 1'b1) begin failures++; $display("FAIL fifo_ready_high got=%b exp=1", bus.req_ready[0]); end
      end
    end
    model = expv;
  endtask

  task automatic test_invalid;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       set_req(0, 20, 10, 64'hFF, 0, 0);
        1:       set_req(0, 190, 200, 64'hFF, 0, 0);
        default: set_req(0, 0, 64, 64'hFF, 0, 0);
      endcase
      tick();
      bus.req_valid = '0;
      checks++; if (err !== 2'b01) begin failures++; $display("FAIL invalid_err i=%0d got=%b exp=01", i, err); end
      checks++; if (ch_busy !== 2'b00) begin failures++; $display("FAIL invalid_busy i=%0d got=%b exp=00", i, ch_busy); end
      tick();
      checks++; if (err !== 2'b00) begin failures++; $display("FAIL invalid_err_clear i=%0d got=%b exp=00", i, err); end
    end
    for (int k = 0; k < 5; k++) tick();
    checks++; if (vector !== model) begin failures++; $display("FAIL invalid_vector got=%h exp=%h", vector, model); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL invalid_done got=%b exp=00", done); end
  endtask

  task automatic test_reset_mid;
    set_req(0, 160, 167, 64'hFF, 0, 8);
    tick();
    bus.req_valid = '0;
    for (int k = 1; k <= 5; k++) tick();
    expv = model;
    expv[167:160] = 8'hFF;
    checks++; if (vector !== expv) begin failures++; $display("FAIL midrst_applied got=%h exp=%h", vector, expv); end
    rst = 1'b1;
    tick();
    checks++; if (vector !== '0) begin failures++; $display("FAIL midrst_vector got=%h exp=0", vector); end
    checks++; if (ch_busy !== 2'b00 || done !== 2'b00) begin failures++; $display("FAIL midrst_status got busy=%b done=%b exp=00", ch_busy, done); end
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL midrst_ready got=%b exp=00", bus.req_ready); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (vector !== '0 || done !== 2'b00 || ch_busy !== 2'b00) begin
        failures++; $display("FAIL midrst_after k=%0d got vector=%h done=%b busy=%b", k, vector, done, ch_busy);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_start = '0;
    bus.req_end   = '0;
    bus.req_val   = '0;
    bus.req_wait  = '0;
    bus.req_pulse = '0;
    model         = '0;
    expv          = '0;
    test_reset();
    test_hold();
    test_pulse();
    test_same_cycle();
    test_boundary();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
